div_unit: RTL

- Iterative 32-bit signed/unsigned divider in the EX stage, directly downstream of the ALU-control decoder.
- It consumes the registered alucontrol code (E stage) and the two operands. It produces {HI=remainder, LO=quotient} for the HI/LO register file.
- It holds the pipeline with a stall signal while the divide runs.
- It aborts cleanly on an EX-stage flush (exception or branch cancel).

---
 rtl/div_unit_pkg.sv | 6 +
 rtl/div_if.sv | 15 +
 rtl/div_unit.sv | 66 ++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// div_unit_pkg: shared ALU control codes and datapath width for the EX-stage divider
package div_unit_pkg;
  localparam int DIV_W = 32;
  localparam logic [4:0] SIG_ALU_DIV = 5'b11010;
  localparam logic [4:0] SIG_ALU_DIVU = 5'b11011;
endpackage

// File: rtl/div_if.sv
// div_if: EX-stage request/response bundle between the pipeline and the divider
interface div_if;
  import div_unit_pkg::*;
  logic [4:0] alucontrolE;
  logic validE;
  logic flushE;
  logic [DIV_W-1:0] srcaE;
  logic [DIV_W-1:0] srcbE;
  logic div_stall;
  logic div_valid;
  logic [DIV_W-1:0] hi_out;
  logic [DIV_W-1:0] lo_out;
  modport master(output alucontrolE, validE, flushE, srcaE, srcbE, input div_stall, div_valid, hi_out, lo_out);
  modport slave(input alucontrolE, validE, flushE, srcaE, srcbE, output div_stall, div_valid, hi_out, lo_out);
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative restoring signed/unsigned divider producing {HI=remainder, LO=quotient}
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ITERS = DATA_W
) (
  input logic clk,
  input logic rst,
  div_if.slave d
);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DZERO = 2'd2, DONE = 2'd3;
  localparam int CW = $clog2(ITERS);
  logic [1:0] state, state_n;
  logic sgn, start, bzero, sign_q, sign_r;
  logic [CW-1:0] count;
  logic [DATA_W-1:0] rem, quo, absb, abs_a, abs_b, hi_q, lo_q, hi_fix, lo_fix;
  logic [DATA_W:0] diff;
  assign sgn = d.alucontrolE == SIG_ALU_DIV;
  assign bzero = d.srcbE == '0;
  assign start = d.validE & ~d.flushE & (sgn | d.alucontrolE == SIG_ALU_DIVU) & state == IDLE;
  assign abs_a = (sgn & d.srcaE[DATA_W-1]) ? -d.srcaE : d.srcaE;
  assign abs_b = (sgn & d.srcbE[DATA_W-1]) ? -d.srcbE : d.srcbE;
  assign diff = {rem, quo[DATA_W-1]} - {1'b0, absb};
  assign hi_fix = sign_r ? -rem : rem;
  assign lo_fix = sign_q ? -quo : quo;
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state; a flush cancels whatever is in flight
  always_comb
    state_n = d.flushE ? IDLE :
              state == IDLE ? (start ? (bzero ? DZERO : BUSY) : IDLE) :
              state == BUSY ? (count == CW'(ITERS - 1) ? DONE : BUSY) :
              state == DZERO ? DONE : IDLE;
  // outputs; results are shown live in DONE and held from hi_q/lo_q otherwise
  always_comb begin
    d.div_stall = ~d.flushE & (start | state == BUSY | state == DZERO);
    d.div_valid = ~d.flushE & state == DONE;
    d.hi_out = d.div_valid ? hi_fix : hi_q;
    d.lo_out = d.div_valid ? lo_fix : lo_q;
  end
  // datapath: divide-by-zero loads its fixed result at start and clears signs to skip the fix-up
  always_ff @(posedge clk)
    if (rst) begin
      {sign_q, sign_r, count, rem, quo, absb, hi_q, lo_q} <= '0;
    end else begin
      if (start) begin
        sign_q <= sgn & ~bzero & (d.srcaE[DATA_W-1] ^ d.srcbE[DATA_W-1]);
        sign_r <= sgn & ~bzero & d.srcaE[DATA_W-1];
        absb <= abs_b;
        count <= '0;
        rem <= bzero ? d.srcaE : '0;
        quo <= bzero ? '1 : abs_a;
      end else if (state == BUSY) begin
        rem <= diff[DATA_W] ? {rem[DATA_W-2:0], quo[DATA_W-1]} : diff[DATA_W-1:0];
        quo <= {quo[DATA_W-2:0], ~diff[DATA_W]};
        count <= count + 1'b1;
      end
      if (d.div_valid) begin
        hi_q <= hi_fix;
        lo_q <= lo_fix;
      end
    end
endmodule
